lsu_bus_bridge: RTL and testbench
=================================

Name: lsu_bus_bridge

Overview:
- Load/store unit directly downstream of the single-cycle datapath.
- Consumes ALUResult (address), WriteData and the load/store control, and runs a req/ack transaction on the data-memory bus.
- Returns a formatted, extended ReadData to the datapath's result mux.
- Holds the core with Stall while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, REQ-state cycles without bus_ack before abort; 0 disables the timeout.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-low reset
- MemRead  input  1  load instruction in execute
- MemWrite  input  1  store instruction in execute
- Funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- ALUResult  input  32  byte address
- WriteData  input  32  store data (rs2)
- ReadData  output  32  formatted load data to the result mux
- Stall  output  1  hold PC/regfile write this cycle
- BusError  output  1  one-cycle pulse on timeout
- MisalignFault  output  1  one-cycle pulse on misaligned access
- bus_req  output  1  transaction request
- bus_we  output  1  1 = write
- bus_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- bus_be  output  4  byte enables
- bus_wdata  output  32  lane-replicated store data
- bus_rdata  input  32  read word
- bus_ack  input  1  transaction complete, sampled in REQ only

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; bus_req, bus_we, BusError, MisalignFault = 0; bus_addr, bus_be, bus_wdata, ReadData = 0; timeout counter = 0. A reset during REQ drops bus_req immediately; any late ack is ignored.
- Access definition: access = MemRead | MemWrite. MemWrite has priority if both are set (store performed, no load data).
- FSM states:
  - IDLE: Stall = access & ~fault (combinational). On access, latch address/Funct3/be/wdata/we and go to REQ.
  - REQ: bus_req = 1, Stall = 1, bus outputs stable from latched values, counter increments.
    - bus_ack=1: capture formatted bus_rdata into ReadData (loads only; stores leave ReadData unchanged), go to DONE.
    - Counter reaches TIMEOUT_CYCLES (nonzero) with no ack: ReadData = 0, BusError = 1 on entering DONE, go to DONE.
  - DONE: Stall = 0 and bus_req = 0 for exactly one cycle; the core retires the instruction on this edge; go to IDLE. The same access is never reissued.
- Latency: with zero-wait memory (ack in the first REQ cycle), Stall is high for 2 cycles and the instruction retires in the 3rd.
- Store formatting:
  - SB: bus_wdata = {4{wd[7:0]}}, bus_be = 4'b0001 << addr[1:0].
  - SH: bus_wdata = {2{wd[15:0]}}, bus_be = addr[1] ? 1100 : 0011.
  - SW: bus_wdata = wd, bus_be = 1111.
  - Loads: bus_be = 1111.
- Load formatting (uses latched addr[1:0]):
  - Byte lane = rdata[8*addr[1:0] +: 8].
  - Halfword = rdata[16*addr[1] +: 16].
  - 000/001 sign-extend; 100/101 zero-extend; 010 full word.
  - Funct3 011/110/111 are treated as 010.
- bus_ack outside REQ is ignored. Counter clears on entry to REQ.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00. Handling is set by the optional feature below.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access in IDLE raises MisalignFault for one cycle, issues no bus transaction, keeps Stall = 0, drives ReadData = 0, and stays in IDLE.
- Undefined: MisalignFault is tied 0. Misaligned accesses proceed with the offending low address bits treated as 0 (halfword uses addr[1] only; word uses lane 0).

Test Plan:
- LW addr 0x100, ack in the first REQ cycle, rdata 0xDEADBEEF -> Stall high for 2 cycles, bus_be=1111, bus_addr=0x100, ReadData=0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80FF0000 -> ReadData=0xFFFFFF80; LBU at the same address -> ReadData=0x00000080.
- SH addr 0x202, WriteData 0x1234ABCD, ack after 3 wait cycles -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD held stable for 4 REQ cycles, Stall low only in DONE.
- TIMEOUT_CYCLES=4, no ack -> BusError pulses once after 4 REQ cycles, ReadData=0, FSM returns to IDLE.
- reset driven 0 mid-REQ -> bus_req falls without waiting for a clock edge; an ack after reset release has no effect; the next LW completes normally.
- LW addr 0x101:
  - with LSU_MISALIGN_TRAP_EN: MisalignFault=1 for one cycle, bus_req never asserts.
  - without it: bus_addr=0x100, word read completes.

Source files
------------

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: load/store unit between the single-cycle datapath and a
// req/ack data-memory bus. Latches the access in IDLE, holds it on the bus in
// REQ until ack or timeout, and releases the core for one DONE cycle.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// instead of silently aligning them.
module lsu_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        BusError,
  output logic        MisalignFault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  localparam int CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TLAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nxt;

  logic          access, fault, go, ack_hit, tmo_hit;
  logic [CW-1:0] cnt;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic [31:0]   rdata_q, load_fmt, wdata_nxt;
  logic [3:0]    be_nxt;
  logic [7:0]    byte_l;
  logic [15:0]   half_l;

  // Store wins when both strobes are set.
  assign access = MemRead | MemWrite;

`ifdef LSU_MISALIGN_TRAP_EN
  logic is_word, is_half, misalign;
  assign is_word  = Funct3[1];
  assign is_half  = ~Funct3[1] & Funct3[0];
  assign misalign = (is_half & ALUResult[0]) | (is_word & (|ALUResult[1:0]));
  assign fault    = (state == IDLE) & access & misalign;
`else
  // Misaligned accesses just drop the offending low address bits.
  assign fault = 1'b0;
`endif

  assign go      = (state == IDLE) & access & ~fault;
  assign ack_hit = (state == REQ) & bus_ack;
  // Ack in the last allowed cycle still wins over the timeout.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) & (state == REQ) & ~bus_ack &
                   (cnt == CW'(TLAST));

  assign MisalignFault = fault;
  assign ReadData      = fault ? 32'h0 : rdata_q;

  // Store lane replication and byte enables; loads always read the full word.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = WriteData;
    if (MemWrite && !Funct3[1]) begin
      if (!Funct3[0]) begin
        be_nxt    = 4'b0001 << ALUResult[1:0];
        wdata_nxt = {4{WriteData[7:0]}};
      end else begin
        be_nxt    = ALUResult[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{WriteData[15:0]}};
      end
    end
  end

  // Load lane select and sign/zero extension from the latched offset/size.
  always_comb begin
    byte_l = bus_rdata[{off_q, 3'b000} +: 8];
    half_l = bus_rdata[{off_q[1], 4'b0000} +: 16];
    if (f3_q[1])      load_fmt = bus_rdata;
    else if (f3_q[0]) load_fmt = {{16{half_l[15] & ~f3_q[2]}}, half_l};
    else              load_fmt = {{24{byte_l[7] & ~f3_q[2]}}, byte_l};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: DONE always falls back to IDLE so an access is never reissued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = REQ;
      REQ:     if (bus_ack || tmo_hit) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: bus_req is combinational from state so reset drops it at once.
  always_comb begin
    Stall   = 1'b0;
    bus_req = 1'b0;
    case (state)
      IDLE:    Stall = access & ~fault;
      REQ: begin
        Stall   = 1'b1;
        bus_req = 1'b1;
      end
      default: ;
    endcase
  end

  // Latched bus request fields, timeout counter and load result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      BusError  <= 1'b0;
    end else begin
      BusError <= tmo_hit;
      if (go) begin
        bus_we    <= MemWrite;
        bus_addr  <= {ALUResult[31:2], 2'b00};
        bus_be    <= be_nxt;
        bus_wdata <= wdata_nxt;
        off_q     <= ALUResult[1:0];
        f3_q      <= Funct3;
        cnt       <= '0;
      end else if (state == REQ) begin
        cnt <= cnt + 1'b1;
      end
      if (fault)                  rdata_q <= '0;
      else if (ack_hit && !bus_we) rdata_q <= load_fmt;
      else if (tmo_hit)           rdata_q <= '0;
    end
  end
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge (TIMEOUT_CYCLES = 4).
module tb_lsu_bus_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, bus_ack;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData, bus_rdata;
  logic [31:0] ReadData, bus_addr, bus_wdata;
  logic        Stall, BusError, MisalignFault, bus_req, bus_we;
  logic [3:0]  bus_be;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] last_rd;

  lsu_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .BusError(BusError),
    .MisalignFault(MisalignFault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Reference: load value from the word using plain shifts and masks.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int unsigned off, v;
    off = addr % 4;
    if (f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return rd;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
    end else begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned off;
    off = addr % 4;
    if (!we || f3 == 3'd2) return 4'hF;
    if (f3 == 3'd0) return 4'(1 << off);
    return 4'(3 << (2 * (off / 2)));
  endfunction

  function automatic logic [31:0] ref_wd(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'd0) return (wd & 32'hFF) * 32'h01010101;
    if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  // One complete access; called and returns at posedge+1 with inputs idle.
  task automatic do_access(input logic we, input logic both, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, input int waits,
                           input logic [31:0] exp_rd, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd);
    MemWrite = we; MemRead = ~we | both; Funct3 = f3;
    ALUResult = addr; WriteData = wd; bus_ack = 1'b0;
    #2;
    check1("idle_stall", Stall, 1'b1);
    check1("idle_req", bus_req, 1'b0);
    check1("idle_mf", MisalignFault, 1'b0);
    @(posedge clk); #1;
    for (int w = 0; w <= waits; w++) begin
      #1;
      check1("req_req", bus_req, 1'b1);
      check1("req_stall", Stall, 1'b1);
      check1("req_we", bus_we, we);
      check("req_addr", bus_addr, addr & 32'hFFFFFFFC);
      check("req_be", {28'h0, bus_be}, {28'h0, exp_be});
      if (we) check("req_wdata", bus_wdata, exp_wd);
      if (w == waits) begin bus_ack = 1'b1; bus_rdata = rdata; end
      else bus_rdata = $urandom;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    #1;
    check1("done_stall", Stall, 1'b0);
    check1("done_req", bus_req, 1'b0);
    check1("done_buserr", BusError, 1'b0);
    check("done_rdata", ReadData, exp_rd);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    check1("no_reissue", bus_req, 1'b0);
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rd, exp;
    logic [2:0]  ld_f3[8];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    tbl[0] = '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1] = '{1'b0, 3'd0, 32'h103, 32'h0,        32'h80FF0000, 1, 32'hFFFFFF80, 4'hF, 32'h0};
    tbl[2] = '{1'b0, 3'd4, 32'h103, 32'h0,        32'h80FF0000, 0, 32'h00000080, 4'hF, 32'h0};
    tbl[3] = '{1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0,        3, 32'h00000080, 4'hC, 32'hABCDABCD};
    tbl[4] = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h80017FFF, 2, 32'hFFFF8001, 4'hF, 32'h0};
    tbl[5] = '{1'b0, 3'd5, 32'h100, 32'h0,        32'h8001F00F, 0, 32'h0000F00F, 4'hF, 32'h0};
    tbl[6] = '{1'b1, 3'd0, 32'h301, 32'h000000A5, 32'h0,        1, 32'h0000F00F, 4'h2, 32'hA5A5A5A5};
    tbl[7] = '{1'b1, 3'd2, 32'h400, 32'h01234567, 32'h0,        0, 32'h0000F00F, 4'hF, 32'h01234567};
    tbl[8] = '{1'b0, 3'd3, 32'h104, 32'h0,        32'hCAFEF00D, 0, 32'hCAFEF00D, 4'hF, 32'h0};
    tbl[9] = '{1'b0, 3'd0, 32'h101, 32'h0,        32'h00007F00, 2, 32'h0000007F, 4'hF, 32'h0};

    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0;
    ALUResult = '0; WriteData = '0; bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_req", bus_req, 1'b0);
    check1("rst_we", bus_we, 1'b0);
    check1("rst_buserr", BusError, 1'b0);
    check1("rst_mf", MisalignFault, 1'b0);
    check1("rst_stall", Stall, 1'b0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_be", {28'h0, bus_be}, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_rdata", ReadData, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed table
    foreach (tbl[i])
      do_access(tbl[i].we, 1'b0, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rdata,
                tbl[i].waits, tbl[i].exp_rd, tbl[i].exp_be, tbl[i].exp_wd);
    last_rd = tbl[9].exp_rd;

    // Both strobes set: store performed, load data unchanged
    do_access(1'b1, 1'b1, 3'd2, 32'h440, 32'h55AA33CC, 32'hFFFFFFFF, 1,
              last_rd, 4'hF, 32'h55AA33CC);

    // Timeout after 4 REQ cycles with no ack
    MemRead = 1'b1; Funct3 = 3'd2; ALUResult = 32'h500; bus_ack = 1'b0;
    @(posedge clk); #1;
    for (int w = 0; w < 4; w++) begin
      #1;
      check1("tmo_req", bus_req, 1'b1);
      check1("tmo_noerr", BusError, 1'b0);
      @(posedge clk); #1;
    end
    #1;
    check1("tmo_buserr", BusError, 1'b1);
    check1("tmo_stall", Stall, 1'b0);
    check1("tmo_req_off", bus_req, 1'b0);
    check("tmo_rdata", ReadData, 32'h0);
    @(posedge clk); #1;
    MemRead = 1'b0;
    check1("tmo_pulse_end", BusError, 1'b0);
    check1("tmo_idle_req", bus_req, 1'b0);
    last_rd = 32'h0;

    // Reset mid-REQ, late ack ignored, next LW completes
    do_access(1'b0, 1'b0, 3'd2, 32'h580, 32'h0, 32'h13579BDF, 0, 32'h13579BDF, 4'hF, 32'h0);
    MemRead = 1'b1; Funct3 = 3'd2; ALUResult = 32'h600;
    @(posedge clk); #1;
    #1;
    check1("mid_req_on", bus_req, 1'b1);
    reset = 1'b0;
    #1;
    check1("mid_rst_req_off", bus_req, 1'b0);
    check("mid_rst_rdata", ReadData, 32'h0);
    MemRead = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hBADBAD00;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check1("late_ack_req", bus_req, 1'b0);
    check1("late_ack_stall", Stall, 1'b0);
    check("late_ack_rdata", ReadData, 32'h0);
    do_access(1'b0, 1'b0, 3'd2, 32'h700, 32'h0, 32'h2468ACE0, 0, 32'h2468ACE0, 4'hF, 32'h0);
    last_rd = 32'h2468ACE0;

    // Misaligned LW 0x101
`ifdef LSU_MISALIGN_TRAP_EN
    MemRead = 1'b1; Funct3 = 3'd2; ALUResult = 32'h101;
    #2;
    check1("mis_fault", MisalignFault, 1'b1);
    check1("mis_stall", Stall, 1'b0);
    check1("mis_req", bus_req, 1'b0);
    check("mis_rdata", ReadData, 32'h0);
    @(posedge clk); #1;
    MemRead = 1'b0;
    #1;
    check1("mis_pulse_end", MisalignFault, 1'b0);
    check1("mis_no_req", bus_req, 1'b0);
    check("mis_rdata_held", ReadData, 32'h0);
    last_rd = 32'h0;
`else
    do_access(1'b0, 1'b0, 3'd2, 32'h101, 32'h0, 32'h89ABCDEF, 1, 32'h89ABCDEF, 4'hF, 32'h0);
    last_rd = 32'h89ABCDEF;
`endif

    // Randomized aligned accesses against the reference model
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(1));
      if (we) f3 = 3'($urandom_range(2));
      else    f3 = ld_f3[$urandom_range(7)];
      addr = $urandom & 32'hFFFFFFFC;
      if (f3 == 3'd0 || f3 == 3'd4)      addr = addr + 32'($urandom_range(3));
      else if (f3 == 3'd1 || f3 == 3'd5) addr = addr + 32'(2 * $urandom_range(1));
      wd = $urandom;
      rd = $urandom;
      exp = we ? last_rd : ref_load(f3, addr, rd);
      do_access(we, we & 1'($urandom_range(1)), f3, addr, wd, rd, $urandom_range(3),
                exp, ref_be(we, f3, addr), ref_wd(f3, wd));
      last_rd = exp;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
